ald_recipe_sequencer: RTL and testbench
=======================================

// Module: ald_recipe_sequencer
// PURPOSE
//  Parametrised ALD recipe sequencer; replaces fixed per-rung valve/heater logic with a programmable step table.
//  Each step holds an actuator mask (valves, heaters, MFC enables) and a dwell time in ms ticks.
//  Runs the recipe for a programmed cycle count and drops all actuators on stop or loss of interlock.
//  Sits between board keys/host loader and the actuator output drivers (LEDR/LEDG on the DE2-115 bench).
// PARAMETERS
//  NUM_OUTPUTS  11      actuator channels (mask width)
//  NUM_STEPS    16      step-table depth; STEP_W = $clog2(NUM_STEPS)
//  DWELL_W      16      dwell field width, in ticks
//  CYCLE_W      16      cycle counter/target width
//  TICK_DIV     50000   clk cycles per tick (1 ms at 50 MHz); >= 2
// PORTS
//  clk            in   1            system clock (CLOCK_50)
//  rst            in   1            synchronous reset, active-low
//  start          in   1            start request, active-high level (inverted KEY)
//  stop           in   1            stop request, active-high level
//  interlock_ok   in   1            1 = pressure/temperature interlocks healthy
//  prog_we        in   1            step-table write strobe
//  prog_addr      in   STEP_W       step index to write
//  prog_mask      in   NUM_OUTPUTS  actuator mask for that step
//  prog_dwell     in   DWELL_W      dwell ticks for that step
//  prog_last      in   1            step ends the cycle
//  cycles_target  in   CYCLE_W      cycles to run; 0 = run until stop
//  act_out        out  NUM_OUTPUTS  registered actuator drive
//  step_counter   out  STEP_W       current step index
//  cycle_count    out  CYCLE_W      completed cycles
//  busy, done, fault  out 1 each    state flags
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): state IDLE, all outputs 0, prescaler 0; step table cleared (mask 0, dwell 0, last 0).
//  - States: IDLE, RUN, DONE, FAULT. busy=RUN, done=DONE, fault=FAULT, all registered.
//  - Start: rising edge of start (registered previous value) in IDLE or DONE with interlock_ok=1 -> RUN;
//    step 0, cycle_count 0, prescaler 0, dwell loaded from entry 0; act_out = mask[0] on the next cycle.
//    start with interlock_ok=0 is ignored.
//  - Tick: prescaler counts 0..TICK_DIV-1 in RUN only; tick pulse is 1 cycle at terminal count.
//  - Dwell: counter loaded on step entry; dwell 0 treated as 1; decrements on tick; at tick with value 1, step ends.
//  - Step end: if last flag set or step == NUM_STEPS-1, cycle ends: cycle_count+1;
//    if cycles_target != 0 and new count == cycles_target -> DONE, else step 0. Otherwise step+1.
//    act_out switches to the new mask in the same cycle step_counter updates.
//  - cycle_count saturates at all-ones when cycles_target=0; no wrap.
//  - stop (level) in RUN or DONE -> IDLE next cycle, act_out 0; step/cycle counts hold for readback.
//    stop has priority over start on the same cycle.
//  - interlock_ok=0 in RUN -> FAULT next cycle, act_out 0; interlock has priority over stop and tick.
//    FAULT exits to IDLE only on stop while interlock_ok=1.
//  - DONE: act_out 0; counts hold.
//  - prog_we honoured only when not RUN; otherwise ignored, no side effect.
//  - Reset mid-run behaves exactly as power-up reset, with the table cleared.
// CONFIGURATION
//  ALD_KEY_DEBOUNCE_EN defined: start/stop pass through a debouncer requiring
//    DEBOUNCE_CYC (localparam 1,000,000 = 20 ms) stable cycles before the filtered level changes;
//    this adds up to DEBOUNCE_CYC+1 cycles of latency.
//  ALD_KEY_DEBOUNCE_EN undefined: start/stop are 2-flop synchronised only (2 cycles latency), no filtering.
// TESTING (TICK_DIV=4, debounce off)
//  - Reset: rst=0 for 2 cycles -> act_out=0, busy=done=fault=0, step_counter=0.
//  - Program steps 0..2 with masks 0x001,0x006,0x400, dwell 2,0,3, last on step 2; cycles_target=2; start
//    -> mask sequence lasts 8,4,12 clks per step; 2 cycles; done=1, cycle_count=2, act_out=0.
//  - cycles_target=0, 1-step table at dwell 1; run 5 cycles, then stop -> IDLE on next clk, act_out=0, cycle_count=5.
//  - interlock_ok=0 mid-step 1 -> fault=1 next clk, act_out=0; stop with interlock_ok=0 -> stays FAULT;
//    stop with interlock_ok=1 -> IDLE.
//  - prog_we to step 0 during RUN -> table entry unchanged after DONE (readback via rerun shows old mask).
//  - start and stop asserted in the same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/ald_recipe_sequencer.sv
// Programmable ALD recipe sequencer: step table of actuator masks and dwell times, run for N cycles.
// Optional key debouncing on start/stop when ALD_KEY_DEBOUNCE_EN is defined.
module ald_recipe_sequencer #(
  parameter int unsigned NUM_OUTPUTS = 11,
  parameter int unsigned NUM_STEPS   = 16,
  parameter int unsigned DWELL_W     = 16,
  parameter int unsigned CYCLE_W     = 16,
  parameter int unsigned TICK_DIV    = 50000,
  localparam int unsigned STEP_W     = $clog2(NUM_STEPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   interlock_ok,
  input  logic                   prog_we,
  input  logic [STEP_W-1:0]      prog_addr,
  input  logic [NUM_OUTPUTS-1:0] prog_mask,
  input  logic [DWELL_W-1:0]     prog_dwell,
  input  logic                   prog_last,
  input  logic [CYCLE_W-1:0]     cycles_target,
  output logic [NUM_OUTPUTS-1:0] act_out,
  output logic [STEP_W-1:0]      step_counter,
  output logic [CYCLE_W-1:0]     cycle_count,
  output logic                   busy,
  output logic                   done,
  output logic                   fault
);
  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]               state, next_state;
  logic [1:0]               start_sync, stop_sync;
  logic                     start_lvl, stop_lvl, start_prev, start_edge;
  logic [PRESC_W-1:0]       presc;
  logic [DWELL_W-1:0]       dwell_cnt;
  logic                     tick, go, step_end, cycle_end, last_step;
  logic [STEP_W-1:0]        next_step;
  logic [CYCLE_W-1:0]       cycle_inc;
  logic [NUM_OUTPUTS-1:0]   tbl_mask  [NUM_STEPS];
  logic [DWELL_W-1:0]       tbl_dwell [NUM_STEPS];
  logic                     tbl_last  [NUM_STEPS];

  // Two-flop synchronisers for the key inputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_sync <= '0;
      stop_sync  <= '0;
    end else begin
      start_sync <= {start_sync[0], start};
      stop_sync  <= {stop_sync[0], stop};
    end
  end

`ifdef ALD_KEY_DEBOUNCE_EN
  localparam int unsigned DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC);
  logic [DB_W-1:0] start_db_cnt, stop_db_cnt;
  logic            start_filt, stop_filt;

  // Filtered level follows the synchronised key only after DEBOUNCE_CYC stable cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_db_cnt <= '0;
      stop_db_cnt  <= '0;
      start_filt   <= 1'b0;
      stop_filt    <= 1'b0;
    end else begin
      if (start_sync[1] == start_filt) start_db_cnt <= '0;
      else if (start_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        start_filt   <= start_sync[1];
        start_db_cnt <= '0;
      end else start_db_cnt <= start_db_cnt + DB_W'(1);
      if (stop_sync[1] == stop_filt) stop_db_cnt <= '0;
      else if (stop_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        stop_filt   <= stop_sync[1];
        stop_db_cnt <= '0;
      end else stop_db_cnt <= stop_db_cnt + DB_W'(1);
    end
  end
  assign start_lvl = start_filt;
  assign stop_lvl  = stop_filt;
`else
  assign start_lvl = start_sync[1];
  assign stop_lvl  = stop_sync[1];
`endif

  assign start_edge = start_lvl & ~start_prev;
  assign tick       = (state == S_RUN) && (presc == PRESC_W'(TICK_DIV - 1));
  assign last_step  = tbl_last[step_counter] || (step_counter == STEP_W'(NUM_STEPS - 1));
  assign next_step  = step_counter + STEP_W'(1);
  assign cycle_inc  = (&cycle_count) ? cycle_count : cycle_count + CYCLE_W'(1);

  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next state; interlock beats stop beats tick in RUN, stop beats start elsewhere
  always_comb begin
    next_state = state;
    go         = 1'b0;
    step_end   = 1'b0;
    cycle_end  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (stop_lvl) next_state = S_IDLE;
        else if (start_edge && interlock_ok) begin
          next_state = S_RUN;
          go         = 1'b1;
        end
      end
      S_RUN: begin
        if (!interlock_ok) next_state = S_FAULT;
        else if (stop_lvl) next_state = S_IDLE;
        else if (tick && (dwell_cnt <= DWELL_W'(1))) begin
          step_end  = 1'b1;
          cycle_end = last_step;
          if (last_step && (cycles_target != '0) && (cycle_inc == cycles_target))
            next_state = S_DONE;
        end
      end
      S_FAULT: if (stop_lvl && interlock_ok) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      start_prev   <= 1'b0;
      presc        <= '0;
      dwell_cnt    <= '0;
      act_out      <= '0;
      step_counter <= '0;
      cycle_count  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      for (int unsigned i = 0; i < NUM_STEPS; i++) begin
        tbl_mask[i]  <= '0;
        tbl_dwell[i] <= '0;
        tbl_last[i]  <= 1'b0;
      end
    end else begin
      start_prev <= start_lvl;
      busy       <= (next_state == S_RUN);
      done       <= (next_state == S_DONE);
      fault      <= (next_state == S_FAULT);
      if (prog_we && (state != S_RUN)) begin
        tbl_mask[prog_addr]  <= prog_mask;
        tbl_dwell[prog_addr] <= prog_dwell;
        tbl_last[prog_addr]  <= prog_last;
      end
      if (go) begin
        step_counter <= '0;
        cycle_count  <= '0;
        presc        <= '0;
        dwell_cnt    <= dwell_load(tbl_dwell[0]);
        act_out      <= tbl_mask[0];
      end else if ((state == S_RUN) && (next_state != S_RUN)) begin
        // Leaving RUN: drop actuators, keep counts for readback
        act_out <= '0;
        presc   <= '0;
        if (cycle_end) cycle_count <= cycle_inc;
      end else if (state == S_RUN) begin
        presc <= tick ? '0 : presc + PRESC_W'(1);
        if (step_end) begin
          if (cycle_end) begin
            cycle_count  <= cycle_inc;
            step_counter <= '0;
            dwell_cnt    <= dwell_load(tbl_dwell[0]);
            act_out      <= tbl_mask[0];
          end else begin
            step_counter <= next_step;
            dwell_cnt    <= dwell_load(tbl_dwell[next_step]);
            act_out      <= tbl_mask[next_step];
          end
        end else if (tick) begin
          dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ald_recipe_sequencer.sv
// Self-checking bench for ald_recipe_sequencer with TICK_DIV=4, debounce disabled.
module tb_ald_recipe_sequencer;
  localparam int unsigned NO = 11;
  localparam int unsigned NS = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned TD = 4;

  logic          clk = 1'b0;
  logic          rst, start, stop, interlock_ok, prog_we, prog_last;
  logic [SW-1:0] prog_addr;
  logic [NO-1:0] prog_mask, act_out;
  logic [DW-1:0] prog_dwell;
  logic [CW-1:0] cycles_target, cycle_count;
  logic [SW-1:0] step_counter;
  logic          busy, done, fault;

  typedef struct packed {
    logic [NO-1:0] mask;
    logic [31:0]   len;
  } seg_t;

  seg_t exp_q[$];
  seg_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ald_recipe_sequencer #(
    .NUM_OUTPUTS(NO), .NUM_STEPS(NS), .DWELL_W(DW), .CYCLE_W(CW), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .interlock_ok(interlock_ok),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_mask(prog_mask),
    .prog_dwell(prog_dwell), .prog_last(prog_last), .cycles_target(cycles_target),
    .act_out(act_out), .step_counter(step_counter), .cycle_count(cycle_count),
    .busy(busy), .done(done), .fault(fault)
  );

  task automatic prog(input int a, input logic [NO-1:0] m, input logic [DW-1:0] d, input logic l);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = SW'(a); prog_mask = m; prog_dwell = d; prog_last = l;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic press_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Monitor: records (mask, length) segments of act_out while busy
  task automatic collect_run(input int budget);
    int   waitc = 0;
    seg_t cur;
    while (!busy && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!busy) begin
      n_checks++; n_fail++;
      $display("FAIL run_start: busy=%0b after %0d cycles, required 1", busy, waitc);
      return;
    end
    cur.mask = act_out;
    cur.len  = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        obs_q.push_back(cur);
        return;
      end
      if (act_out == cur.mask) cur.len++;
      else begin
        obs_q.push_back(cur);
        cur.mask = act_out;
        cur.len  = 1;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL run_end: still busy after %0d cycles, required idle", budget);
    obs_q.push_back(cur);
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; stop = 1'b0; interlock_ok = 1'b1; prog_we = 1'b0;
    prog_addr = '0; prog_mask = '0; prog_dwell = '0; prog_last = 1'b0; cycles_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (act_out !== '0) begin n_fail++; $display("FAIL reset_act: got %h, required 000", act_out); end
    n_checks++; if ({busy, done, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b, required 000", {busy, done, fault}); end
    n_checks++; if (step_counter !== '0) begin n_fail++; $display("FAIL reset_step: got %0d, required 0", step_counter); end
    n_checks++; if (cycle_count !== '0) begin n_fail++; $display("FAIL reset_cycle: got %0d, required 0", cycle_count); end
  endtask

  task automatic test_recipe;
    seg_t e, o;
    prog(0, 11'h001, 16'd2, 1'b0);
    prog(1, 11'h006, 16'd0, 1'b0);
    prog(2, 11'h400, 16'd3, 1'b1);
    cycles_target = 16'd2;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back('{mask: 11'h001, len: 32'd8});
      exp_q.push_back('{mask: 11'h006, len: 32'd4});
      exp_q.push_back('{mask: 11'h400, len: 32'd12});
    end
    press_start;
    collect_run(300);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL recipe_seg: missing, required mask=%h len=%0d", e.mask, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL recipe_seg: got mask=%h len=%0d, required mask=%h len=%0d", o.mask, o.len, e.mask, e.len); end
      end
    end
    if (obs_q.size() != 0) begin n_checks++; n_fail++; $display("FAIL recipe_seg: %0d extra segments, required 0", obs_q.size()); obs_q.delete(); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL recipe_done: got %b, required 1", done); end
    n_checks++; if (cycle_count !== 16'd2) begin n_fail++; $display("FAIL recipe_cycles: got %0d, required 2", cycle_count); end
    n_checks++; if (act_out !== '0) begin n_fail++; $display("FAIL recipe_act_done: got %h, required 000", act_out); end
  endtask

  task automatic test_free_run;
    int exp_cnt[$];
    int last = 0, t = 0, tlast = 0, k = 0, e;
    prog(0, 11'h155, 16'd1, 1'b1);
    cycles_target = '0;
    for (int i = 1; i <= 5; i++) exp_cnt.push_back(i);
    press_start;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    n_checks++; if (act_out !== 11'h155) begin n_fail++; $display("FAIL free_act: got %h, required 155", act_out); end
    while (exp_cnt.size() > 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (int'(cycle_count) != last) begin
        e = exp_cnt.pop_front();
        n_checks++;
        if (int'(cycle_count) != e || (t - tlast) != 4) begin
          n_fail++; $display("FAIL free_cycle: got count=%0d after %0d clks, required %0d after 4", cycle_count, t - tlast, e);
        end
        last = int'(cycle_count); tlast = t;
      end
    end
    if (exp_cnt.size() != 0) begin n_checks++; n_fail++; $display("FAIL free_timeout: %0d cycles missing, required 0", exp_cnt.size()); end
    stop = 1'b1;
    k = 0;
    while (busy && k < 10) begin @(negedge clk); k++; end
    n_checks++; if (k != 3) begin n_fail++; $display("FAIL stop_latency: got %0d clks, required 3", k); end
    n_checks++; if (act_out !== '0) begin n_fail++; $display("FAIL stop_act: got %h, required 000", act_out); end
    n_checks++; if (cycle_count !== 16'd5) begin n_fail++; $display("FAIL stop_cycles: got %0d, required 5", cycle_count); end
    stop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_interlock;
    int k = 0;
    prog(0, 11'h001, 16'd1, 1'b0);
    prog(1, 11'h006, 16'd5, 1'b1);
    cycles_target = '0;
    press_start;
    while (step_counter != SW'(1) && k < 30) begin @(negedge clk); k++; end
    n_checks++; if (!busy || step_counter !== SW'(1)) begin n_fail++; $display("FAIL il_step1: got busy=%b step=%0d, required busy=1 step=1", busy, step_counter); end
    repeat (2) @(negedge clk);
    interlock_ok = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy, fault} !== 2'b01) begin n_fail++; $display("FAIL il_fault: got busy,fault=%b, required 01", {busy, fault}); end
    n_checks++; if (act_out !== '0) begin n_fail++; $display("FAIL il_act: got %h, required 000", act_out); end
    stop = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL il_stay_fault: got %b, required 1", fault); end
    interlock_ok = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy, done, fault} !== 3'b000) begin n_fail++; $display("FAIL il_exit: got %b, required 000", {busy, done, fault}); end
    stop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_prog_lock;
    seg_t e, o;
    prog(0, 11'h0F0, 16'd1, 1'b1);
    cycles_target = 16'd3;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back('{mask: 11'h0F0, len: 32'd12});
      press_start;
      if (r == 0) begin
        fork
          collect_run(100);
          begin
            repeat (4) @(negedge clk);
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lock_busy: got %b, required 1", busy); end
            prog_we = 1'b1; prog_addr = '0; prog_mask = 11'h7FF; prog_dwell = 16'd9; prog_last = 1'b0;
            @(negedge clk);
            prog_we = 1'b0;
          end
        join
      end else begin
        collect_run(100);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin
          n_fail++; $display("FAIL lock_seg: missing, required mask=%h len=%0d", e.mask, e.len);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin n_fail++; $display("FAIL lock_seg: run %0d got mask=%h len=%0d, required mask=%h len=%0d", r, o.mask, o.len, e.mask, e.len); end
        end
      end
      if (obs_q.size() != 0) begin n_checks++; n_fail++; $display("FAIL lock_seg: %0d extra segments, required 0", obs_q.size()); obs_q.delete(); end
      n_checks++; if (done !== 1'b1 || cycle_count !== 16'd3) begin n_fail++; $display("FAIL lock_done: got done=%b count=%0d, required done=1 count=3", done, cycle_count); end
    end
  endtask

  task automatic test_start_stop;
    stop = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL done_stop: got busy,done=%b, required 00", {busy, done}); end
    stop = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_busy: cycle %0d got %b, required 0", i, busy); end
    end
    start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_release: got %b, required 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    seg_t e, o;
    int   k = 0;
    prog(0, 11'h3FF, 16'd4, 1'b1);
    cycles_target = 16'd1;
    press_start;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_checks++; if ({busy, act_out} !== '0) begin n_fail++; $display("FAIL midrst_out: got busy=%b act=%h, required 0/000", busy, act_out); end
    n_checks++; if (step_counter !== '0 || cycle_count !== '0) begin n_fail++; $display("FAIL midrst_cnt: got step=%0d count=%0d, required 0/0", step_counter, cycle_count); end
    // Cleared table: 16 steps of mask 0, each dwell 0 -> 1 tick
    exp_q.push_back('{mask: 11'h000, len: 32'd64});
    press_start;
    collect_run(200);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL midrst_seg: missing, required mask=%h len=%0d", e.mask, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL midrst_seg: got mask=%h len=%0d, required mask=%h len=%0d", o.mask, o.len, e.mask, e.len); end
      end
    end
    if (obs_q.size() != 0) begin n_checks++; n_fail++; $display("FAIL midrst_seg: %0d extra segments, required 0", obs_q.size()); obs_q.delete(); end
    n_checks++; if (done !== 1'b1 || cycle_count !== 16'd1) begin n_fail++; $display("FAIL midrst_done: got done=%b count=%0d, required 1/1", done, cycle_count); end
  endtask

  initial begin
    test_reset;
    test_recipe;
    test_free_run;
    test_interlock;
    test_prog_lock;
    test_start_stop;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
